uart_cmd_rx: RTL and testbench
==============================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per serial bit (10 MHz, 115200 baud); legal range 4..4095.
REQ-002 SHALL have parameter TIMEOUT_BITS, default 32, meaning inter-byte timeout in bit periods; legal range 1..255.
REQ-003 SHALL have port clock  input  1  system clock; one clock only, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port ena  input  1  block enable.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port a  output  8  operand A of the last accepted command.
REQ-008 SHALL have port b  output  8  operand B of the last accepted command.
REQ-009 SHALL have port opcode  output  3  ALU opcode of the last accepted command.
REQ-010 SHALL have port cmd_valid  output  1  one-cycle pulse when a new command is accepted.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-012 SHALL have port busy  output  1  high while a byte frame is being received.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value (rx_s).
REQ-014 SHALL implement byte FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-015 SHALL leave IDLE on the first cycle rx_s is low; busy SHALL be high from that cycle until the FSM re-enters IDLE.
REQ-016 SHALL, in START, sample rx_s after CLKS_PER_BIT/2 cycles (integer division); if it is high, return to IDLE as a glitch with no output pulse.
REQ-017 SHALL sample 8 data bits, LSB first, each CLKS_PER_BIT cycles after the previous sample, then sample the stop bit after another CLKS_PER_BIT cycles.
REQ-018 SHALL, on a high stop bit, deliver the byte to the command assembler; on a low stop bit, discard the byte, pulse frame_err, and return the assembler to WAIT_HDR.
REQ-019 SHALL return to IDLE on the cycle after the stop-bit sample, so a start bit immediately after the stop bit is accepted.
REQ-020 SHALL implement assembler FSM WAIT_HDR -> WAIT_A -> WAIT_B -> WAIT_HDR.
REQ-021 SHALL, in WAIT_HDR, accept a byte only if bits[7:3] = 5'b10100, latch bits[2:0] as the pending opcode, and go to WAIT_A; any other byte SHALL be dropped and the FSM SHALL stay in WAIT_HDR.
REQ-022 SHALL, in WAIT_A, latch the byte as pending A and go to WAIT_B.
REQ-023 SHALL, in WAIT_B, update a, b and opcode together from the pending values and the received byte, pulse cmd_valid in the cycle after the stop-bit-sampling edge, and go to WAIT_HDR.
REQ-024 SHALL hold a, b and opcode stable between accepted commands; partial or aborted commands SHALL never alter them.
REQ-025 SHALL count bit periods while in WAIT_A or WAIT_B with the byte FSM in IDLE; on reaching TIMEOUT_BITS it SHALL return to WAIT_HDR, discard the pending fields, and emit no pulse.
REQ-026 SHALL clear the timeout counter whenever a byte is delivered or the assembler is in WAIT_HDR.
REQ-027 SHALL, while ena=0, force both FSMs to IDLE/WAIT_HDR, hold cmd_valid, frame_err and busy low, and retain a, b and opcode.
REQ-028 SHALL never assert cmd_valid and frame_err in the same cycle.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, set a=0, b=0, opcode=0, cmd_valid=0, frame_err=0, busy=0, byte FSM=IDLE, assembler=WAIT_HDR, all counters=0, and synchronizer flops=1.
REQ-030 SHALL give reset priority over ena and over any frame in progress; a frame interrupted by reset SHALL be lost, and reception SHALL resume at the next falling edge after reset is released.

Verification (CLKS_PER_BIT=8, TIMEOUT_BITS=4)
REQ-031 SHALL cover reset: assert reset for 2 cycles with rx=1 -> a=0x00, b=0x00, opcode=0, all pulses low, busy=0.
REQ-032 SHALL cover a nominal command: send bytes 0xA3, 0x05, 0x09 back-to-back -> exactly one cmd_valid with opcode=3, a=0x05, b=0x09; busy low after the last frame.
REQ-033 SHALL cover a bad header: send 0x55, then 0xA6, 0x12, 0x34 -> exactly one cmd_valid with opcode=6, a=0x12, b=0x34.
REQ-034 SHALL cover a framing error: send 0xA1, then 0x07 with its stop bit low, then 0xA2, 0x01, 0x02 -> one frame_err pulse, no cmd_valid until the final command, then opcode=2, a=0x01, b=0x02.
REQ-035 SHALL cover a glitch: drive rx low for 2 cycles then high -> busy returns low within 8 cycles; no pulses; outputs unchanged.
REQ-036 SHALL cover timeout and mid-frame reset: send 0xA4, 0x10, idle 40 cycles, send 0x20 -> no cmd_valid; then assert reset during the data bits of a frame -> outputs return to zero, and the next full command is accepted.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver feeding a three-byte command assembler (header, A, B).
// A command latches a/b/opcode together and pulses cmd_valid once.
//
// byte FSM state | meaning
// S_IDLE         | line idle, waiting for rx_s low
// S_START        | half-bit wait, confirm start bit
// S_DATA         | sampling 8 data bits LSB first
// S_STOP         | sampling stop bit, deliver or flag frame error
//
// assembler state | meaning
// A_WAIT_HDR      | waiting for header byte 10100ooo
// A_WAIT_A        | waiting for operand A
// A_WAIT_B        | waiting for operand B
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [2:0] opcode,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = 12;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    TO_RELOAD   = 8'(TIMEOUT_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} byte_state_t;
  typedef enum logic [1:0] {A_WAIT_HDR, A_WAIT_A, A_WAIT_B} asm_state_t;

  byte_state_t   byte_state;
  asm_state_t    asm_state;
  logic          rx_m, rx_s;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [2:0]    pend_op;
  logic [7:0]    pend_a;
  logic [CW-1:0] tick_cnt;
  logic [7:0]    to_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_state <= S_IDLE;
      asm_state  <= A_WAIT_HDR;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      pend_op    <= '0;
      pend_a     <= '0;
      tick_cnt   <= '0;
      to_cnt     <= '0;
      a          <= '0;
      b          <= '0;
      opcode     <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else if (!ena) begin
      byte_state <= S_IDLE;
      asm_state  <= A_WAIT_HDR;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;

      // Inter-byte timeout only runs between frames of a partial command.
      if (asm_state == A_WAIT_HDR) begin
        tick_cnt <= BIT_RELOAD;
        to_cnt   <= TO_RELOAD;
      end else if (byte_state == S_IDLE) begin
        if (tick_cnt != '0) begin
          tick_cnt <= tick_cnt - CW'(1);
        end else begin
          tick_cnt <= BIT_RELOAD;
          if (to_cnt == '0) begin
            asm_state <= A_WAIT_HDR;
            pend_op   <= '0;
            pend_a    <= '0;
          end else begin
            to_cnt <= to_cnt - 8'd1;
          end
        end
      end

      unique case (byte_state)
        S_IDLE: begin
          if (!rx_s) begin
            byte_state <= S_START;
            bit_cnt    <= HALF_RELOAD;
            busy       <= 1'b1;
          end
        end
        S_START: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CW'(1);
          end else if (rx_s) begin
            byte_state <= S_IDLE;
            busy       <= 1'b0;
          end else begin
            byte_state <= S_DATA;
            bit_cnt    <= BIT_RELOAD;
            bit_idx    <= '0;
          end
        end
        S_DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CW'(1);
          end else begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= BIT_RELOAD;
            if (bit_idx == 3'd7) byte_state <= S_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CW'(1);
          end else begin
            byte_state <= S_IDLE;
            busy       <= 1'b0;
            if (rx_s) begin
              tick_cnt <= BIT_RELOAD;
              to_cnt   <= TO_RELOAD;
              unique case (asm_state)
                A_WAIT_HDR: begin
                  if (shift[7:3] == 5'b10100) begin
                    pend_op   <= shift[2:0];
                    asm_state <= A_WAIT_A;
                  end
                end
                A_WAIT_A: begin
                  pend_a    <= shift;
                  asm_state <= A_WAIT_B;
                end
                A_WAIT_B: begin
                  a         <= pend_a;
                  b         <= shift;
                  opcode    <= pend_op;
                  cmd_valid <= 1'b1;
                  asm_state <= A_WAIT_HDR;
                end
                default: asm_state <= A_WAIT_HDR;
              endcase
            end else begin
              frame_err <= 1'b1;
              asm_state <= A_WAIT_HDR;
            end
          end
        end
        default: byte_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed scenarios plus random byte streams,
// with a command-level reference model feeding a cmd_valid scoreboard.
module tb_uart_cmd_rx;

  localparam int CPB = 8;
  localparam int TOB = 4;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ena   = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] a, b;
  logic [2:0] opcode;
  logic       cmd_valid, frame_err, busy;

  int checks   = 0;
  int failures = 0;

  cmd_t       exp_q[$];
  int         fe_exp  = 0;
  int         fe_seen = 0;
  int         m_phase = 0;
  logic [2:0] m_op    = '0;
  logic [7:0] m_a     = '0;
  logic [7:0] exp_a   = '0;
  logic [7:0] exp_b   = '0;
  logic [2:0] exp_op  = '0;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clock(clock), .reset(reset), .ena(ena), .rx(rx),
    .a(a), .b(b), .opcode(opcode),
    .cmd_valid(cmd_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Command-level model: header/A/B sequencing, frame errors abort, long gaps abort.
  task automatic model_byte(input logic [7:0] d, input bit stop_ok);
    if (!stop_ok) begin
      m_phase = 0;
      fe_exp++;
    end else if (m_phase == 0) begin
      if (d[7:3] == 5'b10100) begin
        m_op    = d[2:0];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_a     = d;
      m_phase = 2;
    end else begin
      exp_q.push_back('{op: m_op, a: m_a, b: d});
      exp_op  = m_op;
      exp_a   = m_a;
      exp_b   = d;
      m_phase = 0;
    end
  endtask

  task automatic model_idle(input int cycles);
    if (cycles >= TOB * CPB) m_phase = 0;
  endtask

  task automatic model_reset();
    m_phase = 0;
    exp_a   = '0;
    exp_b   = '0;
    exp_op  = '0;
    exp_q.delete();
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok);
    model_byte(d, stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_ok ? 1'b1 : 1'b0);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clock);
    end
    chk("hold_a", a, exp_a);
    chk("hold_b", b, exp_b);
    chk("hold_opcode", opcode, exp_op);
  endtask

  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clock);
    model_idle(cycles);
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (!reset) begin
      if (cmd_valid || frame_err) chk("pulse_exclusive", 32'(cmd_valid & frame_err), 0);
      if (frame_err) fe_seen++;
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd_valid actual a=0x%0h b=0x%0h op=%0d required no pulse at %0t",
                   a, b, opcode, $time);
        end else begin
          cmd_t e;
          e = exp_q.pop_front();
          chk("cmd_opcode", opcode, e.op);
          chk("cmd_a", a, e.a);
          chk("cmd_b", b, e.b);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    bit         ok;
    int         gap;

    // Reset
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    idle(4);

    // Nominal command
    send_byte(8'hA3, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h09, 1'b1);
    @(negedge clock);
    chk("nominal_busy_low", busy, 0);
    chk("nominal_drained", exp_q.size(), 0);
    idle(20);

    // Bad header then valid command
    send_byte(8'h55, 1'b1);
    send_byte(8'hA6, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    chk("badhdr_drained", exp_q.size(), 0);
    idle(20);

    // Framing error aborts the partial command
    send_byte(8'hA1, 1'b1);
    send_byte(8'h07, 1'b0);
    send_byte(8'hA2, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    chk("fe_count", fe_seen, fe_exp);
    chk("fe_drained", exp_q.size(), 0);
    idle(20);

    // Glitch on the line
    rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (8) @(negedge clock);
    chk("glitch_busy_low", busy, 0);
    chk("glitch_a", a, exp_a);
    chk("glitch_b", b, exp_b);
    chk("glitch_opcode", opcode, exp_op);
    chk("glitch_fe_count", fe_seen, fe_exp);
    idle(20);

    // Inter-byte timeout
    send_byte(8'hA4, 1'b1);
    send_byte(8'h10, 1'b1);
    idle(40);
    send_byte(8'h20, 1'b1);
    idle(20);
    chk("timeout_a", a, exp_a);
    chk("timeout_b", b, exp_b);
    chk("timeout_opcode", opcode, exp_op);

    // Reset in the middle of a frame
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("midrst_a", a, 0);
    chk("midrst_b", b, 0);
    chk("midrst_opcode", opcode, 0);
    chk("midrst_busy", busy, 0);
    send_byte(8'hA7, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'hCC, 1'b1);
    chk("midrst_drained", exp_q.size(), 0);
    idle(20);

    // Random byte stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 4) d = {5'b10100, 3'($urandom_range(0, 7))};
      else d = 8'($urandom);
      ok = ($urandom_range(0, 9) != 0);
      send_byte(d, ok);
      if ($urandom_range(0, 9) == 0) gap = 40 + int'($urandom_range(0, 20));
      else gap = int'($urandom_range(0, 16));
      if (gap > 0) idle(gap);
    end

    idle(30);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_fe_count", fe_seen, fe_exp);
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
